// File: rtl/oled_frame_scheduler_pkg.sv
// Shared OLED definitions: controller command bytes, D/C levels and the
// frame scheduler state encoding. Power-up sequencing reuses these constants.
package oled_pkg;

  localparam logic [7:0] OLED_CMD_SET_PAGE = 8'hB0;
  localparam logic [7:0] OLED_CMD_COL_LO   = 8'h00;
  localparam logic [7:0] OLED_CMD_COL_HI   = 8'h10;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD_PAGE,
    ST_CMD_COLLO,
    ST_CMD_COLHI,
    ST_FETCH,
    ST_LOAD,
    ST_DATA,
    ST_NEXT_PAGE,
    ST_DONE
  } oled_state_e;

  // Page address command; the controller takes the page number in the low bits.
  function automatic logic [7:0] oled_page_cmd(input logic [2:0] page);
    return OLED_CMD_SET_PAGE | {5'b0, page};
  endfunction

endpackage

// File: rtl/oled_frame_scheduler_if.sv
// Byte stream to the SPI serializer plus the framebuffer read port.
// master = frame scheduler, slave = serializer / framebuffer side.
interface oled_frame_scheduler_if #(
  parameter int ADDR_W = 9
);
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_dc;
  logic              tx_ready;
  logic              fb_rd;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;

  modport master (
    output tx_valid, tx_data, tx_dc, fb_rd, fb_addr,
    input  tx_ready, fb_data
  );

  modport slave (
    input  tx_valid, tx_data, tx_dc, fb_rd, fb_addr,
    output tx_ready, fb_data
  );
endinterface

// File: rtl/oled_frame_scheduler.sv
// Streams one framebuffer per request to the OLED: per page three address
// commands, then COLUMNS pixel bytes fetched one at a time from the RAM.
//
// state        | meaning
// IDLE         | waiting for enable & (frame_req | pending)
// CMD_PAGE     | send set-page command (B0|page), dc=0
// CMD_COLLO    | send column low nibble command, dc=0
// CMD_COLHI    | send column high nibble command, dc=0
// FETCH        | framebuffer read strobe for page*COLUMNS+col
// LOAD         | capture read data into the tx byte register
// DATA         | offer pixel byte, dc=1, until handshake
// NEXT_PAGE    | clear column, advance page or finish
// DONE         | frame complete, pulse frame_done next cycle
module oled_frame_scheduler
  import oled_pkg::*;
#(
  parameter int PAGES   = 4,
  parameter int COLUMNS = 128,
  parameter int ADDR_W  = 9
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic frame_req_i,
  output logic busy_o,
  output logic frame_done_o,
  oled_frame_scheduler_if.master bus
);

  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLUMNS - 1);

  oled_state_e       state_q, state_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              pending_q, pending_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              abort;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      page_q    <= '0;
      col_q     <= '0;
      pending_q <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      col_q     <= col_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    col_d     = col_q;
    pending_d = pending_q;
    data_d    = data_q;
    done_d    = 1'b0;
    abort     = 1'b0;

    // Requests arriving while a frame is in flight collapse into one pending frame.
    if (enable_i && frame_req_i && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i && (frame_req_i || pending_q)) begin
          state_d   = ST_CMD_PAGE;
          pending_d = 1'b0;
        end
      end
      ST_CMD_PAGE: begin
        if (bus.tx_ready) begin
          if (!enable_i) abort = 1'b1;
          else           state_d = ST_CMD_COLLO;
        end
      end
      ST_CMD_COLLO: begin
        if (bus.tx_ready) begin
          if (!enable_i) abort = 1'b1;
          else           state_d = ST_CMD_COLHI;
        end
      end
      ST_CMD_COLHI: begin
        if (bus.tx_ready) begin
          if (!enable_i) abort = 1'b1;
          else           state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!enable_i) abort = 1'b1;
        else           state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!enable_i) begin
          abort = 1'b1;
        end else begin
          data_d  = bus.fb_data;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.tx_ready) begin
          if (!enable_i) begin
            abort = 1'b1;
          end else if (col_q == COL_LAST) begin
            state_d = ST_NEXT_PAGE;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_NEXT_PAGE: begin
        col_d = '0;
        if (!enable_i) begin
          abort = 1'b1;
        end else if (page_q == PAGE_LAST) begin
          state_d = ST_DONE;
        end else begin
          page_d  = page_q + PAGE_W'(1);
          state_d = ST_CMD_PAGE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        page_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      page_d    = '0;
      col_d     = '0;
      pending_d = 1'b0;
    end
  end

  // Address only moves during FETCH so the RAM sees a quiet bus otherwise.
  always_comb begin
    addr_d = addr_q;
    if (state_q == ST_FETCH) begin
      addr_d = ADDR_W'(page_q) * ADDR_W'(COLUMNS) + ADDR_W'(col_q);
    end
  end

  always_comb begin
    bus.tx_data = 8'h00;
    unique case (state_q)
      ST_CMD_PAGE:  bus.tx_data = oled_page_cmd(3'(page_q));
      ST_CMD_COLLO: bus.tx_data = OLED_CMD_COL_LO;
      ST_CMD_COLHI: bus.tx_data = OLED_CMD_COL_HI;
      ST_DATA:      bus.tx_data = data_q;
      default:      bus.tx_data = 8'h00;
    endcase
  end

  assign bus.tx_valid = (state_q == ST_CMD_PAGE) || (state_q == ST_CMD_COLLO) ||
                        (state_q == ST_CMD_COLHI) || (state_q == ST_DATA);
  assign bus.tx_dc    = ((state_q == ST_LOAD) || (state_q == ST_DATA)) ? DC_DATA : DC_CMD;
  assign bus.fb_rd    = (state_q == ST_FETCH);
  assign bus.fb_addr  = addr_d;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = done_q;

endmodule
